sobel_window: RTL

Builds the 3x3 neighbourhood for the Sobel operator from a raster pixel stream. Uses two `line_delay` instances to produce the vertical taps and a 3-deep column shift register per row for the horizontal taps. Zero-pads outside the image border and flushes the last line itself, so it emits exactly one window per input pixel. Sits between the pixel source and the Sobel gradient stage.

---
 rtl/sobel_window_if.sv | 25 ++
 rtl/sobel_window.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/sobel_window_if.sv
// Pixel-stream input and 3x3 window output of sobel_window, bundled for port connection.
// slave is the window builder's view; master is the source/sink side.
interface sobel_window_if #(
  parameter int DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0]   s_data;
  logic                    s_valid;
  logic                    s_sof;
  logic                    s_ready;
  logic [9*DATA_WIDTH-1:0] m_win;
  logic                    m_valid;
  logic                    m_sof;
  logic                    m_eol;
  logic                    m_eof;

  modport slave (
    input  s_data, s_valid, s_sof,
    output s_ready, m_win, m_valid, m_sof, m_eol, m_eof
  );

  modport master (
    output s_data, s_valid, s_sof,
    input  s_ready, m_win, m_valid, m_sof, m_eol, m_eof
  );
endinterface

// File: rtl/sobel_window.sv
// 3x3 Sobel neighbourhood builder: two line delays give the vertical taps, per-row column
// registers give the horizontal taps; border taps are zeroed and the last line is self-flushed.

module line_delay #(
  parameter int WIDTH      = 8,
  parameter int LINE_WIDTH = 1920
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);
  localparam int PW = (LINE_WIDTH > 1) ? $clog2(LINE_WIDTH) : 1;
  localparam logic [PW-1:0] PTR_LAST = PW'(LINE_WIDTH - 1);

  logic [WIDTH-1:0] mem [LINE_WIDTH];
  logic [PW-1:0]    ptr;

  // Read-before-write at the same slot: dout is the sample from exactly LINE_WIDTH enables ago,
  // aligned with din, so the caller sees no pipeline skew.
  assign dout = mem[ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= '0;
    end else if (en) begin
      ptr <= (ptr == PTR_LAST) ? '0 : ptr + PW'(1);
    end
  end

  // NOTE: storage is deliberately not reset; stale lines are masked by the border logic.
  always_ff @(posedge clk) begin
    if (en) mem[ptr] <= din;
  end
endmodule

module sobel_window #(
  parameter int IMG_WIDTH  = 1920,
  parameter int IMG_HEIGHT = 1080,
  parameter int DATA_WIDTH = 8
) (
  input logic          clk,
  input logic          rst,
  sobel_window_if.slave io
);
  localparam int XW = $clog2(IMG_WIDTH + 1);
  localparam int YW = $clog2(IMG_HEIGHT + 1);
  localparam int FW = $clog2(IMG_WIDTH + 2);
  localparam logic [XW-1:0] X_LAST     = XW'(IMG_WIDTH - 1);
  localparam logic [YW-1:0] Y_LAST     = YW'(IMG_HEIGHT - 1);
  localparam logic [FW-1:0] FILL_DONE  = FW'(IMG_WIDTH + 1);
  localparam logic [FW-1:0] FLUSH_LAST = FW'(IMG_WIDTH);

  typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

  state_t                  state;
  logic [XW-1:0]           in_x, out_x;
  logic [YW-1:0]           in_y, out_y;
  logic [FW-1:0]           fill_cnt, flush_cnt;

  logic                    restart, take, beat, emit, last_pixel;
  logic [DATA_WIDTH-1:0]   beat_data, line_mid, line_top;
  logic [DATA_WIDTH-1:0]   col [3][2];
  logic [DATA_WIDTH-1:0]   tap [3][3];
  logic [2:0]              row_out, col_out;
  logic [9*DATA_WIDTH-1:0] win_next;

  always_comb begin
    restart    = io.s_valid && io.s_sof && (state != FLUSH);
    take       = io.s_valid && ((state == RUN) || restart);
    beat       = take || (state == FLUSH);
    beat_data  = (state == FLUSH) ? '0 : io.s_data;
    last_pixel = take && !restart && (in_x == X_LAST) && (in_y == Y_LAST);
    emit       = beat && !restart && (fill_cnt == FILL_DONE);
  end

  line_delay #(.WIDTH(DATA_WIDTH), .LINE_WIDTH(IMG_WIDTH)) u_line1 (
    .clk(clk), .rst(rst), .en(beat), .din(beat_data), .dout(line_mid)
  );

  line_delay #(.WIDTH(DATA_WIDTH), .LINE_WIDTH(IMG_WIDTH)) u_line2 (
    .clk(clk), .rst(rst), .en(beat), .din(line_mid), .dout(line_top)
  );

  // Column 2 of every row is the incoming beat itself; only the two older columns are stored.
  always_comb begin
    tap[0][2] = line_top;
    tap[1][2] = line_mid;
    tap[2][2] = beat_data;
    for (int r = 0; r < 3; r++) begin
      tap[r][0] = col[r][0];
      tap[r][1] = col[r][1];
    end
  end

  always_ff @(posedge clk) begin
    if (beat) begin
      for (int r = 0; r < 3; r++) begin
        col[r][0] <= col[r][1];
        col[r][1] <= tap[r][2];
      end
    end
  end

  always_comb begin
    row_out = {out_y == Y_LAST, 1'b0, out_y == '0};
    col_out = {out_x == X_LAST, 1'b0, out_x == '0};
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    win_next = '0;
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 3; c++) begin
        if (!(row_out[r] || col_out[c])) begin
          win_next[(3*r+c)*DATA_WIDTH +: DATA_WIDTH] = tap[r][c];
        end
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments only; a later assignment in the block wins.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      in_x       <= '0;
      in_y       <= '0;
      out_x      <= '0;
      out_y      <= '0;
      fill_cnt   <= '0;
      flush_cnt  <= '0;
      io.s_ready <= 1'b1;
      io.m_valid <= 1'b0;
      io.m_sof   <= 1'b0;
      io.m_eol   <= 1'b0;
      io.m_eof   <= 1'b0;
      io.m_win   <= '0;
    end else begin
      io.m_valid <= emit;
      io.m_sof   <= emit && (out_x == '0) && (out_y == '0);
      io.m_eol   <= emit && (out_x == X_LAST);
      io.m_eof   <= emit && (out_x == X_LAST) && (out_y == Y_LAST);

      if (emit) begin
        io.m_win <= win_next;
        if (out_x == X_LAST) begin
          out_x <= '0;
          out_y <= (out_y == Y_LAST) ? '0 : out_y + YW'(1);
        end else begin
          out_x <= out_x + XW'(1);
        end
      end

      if (beat && (fill_cnt != FILL_DONE)) fill_cnt <= fill_cnt + FW'(1);

      case (state)
        IDLE: begin
        end
        RUN: begin
          if (take && !restart) begin
            if (in_x == X_LAST) begin
              in_x <= '0;
              in_y <= (in_y == Y_LAST) ? '0 : in_y + YW'(1);
            end else begin
              in_x <= in_x + XW'(1);
            end
            if (last_pixel) begin
              state      <= FLUSH;
              io.s_ready <= 1'b0;
              flush_cnt  <= '0;
            end
          end
        end
        FLUSH: begin
          if (flush_cnt == FLUSH_LAST) begin
            state      <= IDLE;
            io.s_ready <= 1'b1;
          end else begin
            flush_cnt <= flush_cnt + FW'(1);
          end
        end
        default: state <= IDLE;
      endcase

      // An SOF pixel is pixel (0,0) of a fresh frame, whatever was in progress.
      if (restart) begin
        state    <= RUN;
        in_x     <= XW'(1);
        in_y     <= '0;
        out_x    <= '0;
        out_y    <= '0;
        fill_cnt <= FW'(1);
      end
    end
  end
endmodule
